muldiv_seq: RTL and testbench

Sequential 16-bit unsigned multiply/divide unit for the basic CPU datapath. It takes its operands from the two register-file read ports and hands a registered result back toward the register-file write-data mux and the zero-flag flip-flop. It extends the single-cycle ALU with multi-cycle MUL and DIV operations, using a start/busy/done handshake that the control unit uses to stall the PC.

---
 rtl/muldiv_seq.sv | 174 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential 16-bit unsigned multiply (shift-add) / divide (restoring) unit.
// Latency: 16 iterations, done 17 cycles after the start cycle; divide-by-zero completes in 1.
// Backpressure: none; start is ignored while busy, and results hold until the next completion.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] res_lo,
  output logic [15:0] res_hi,
  output logic        zero,
  output logic        dz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  // Multiply: {partial product high half, remaining multiplier bits}.
  // Divide: low half holds the dividend shifting out / quotient shifting in.
  logic [31:0] acc_q, acc_d;
  // Restored remainder is always below the divisor, so 16 bits suffice;
  // the 17-bit partial remainder exists only combinationally (div_shift).
  logic [15:0] rem_q, rem_d;
  logic [15:0] res_lo_q, res_lo_d;
  logic [15:0] res_hi_q, res_hi_d;
  logic        zero_q, zero_d;
  logic        dz_q, dz_d;

  logic        accept;
  logic        div_by_zero;
  logic [16:0] mul_sum;
  logic [31:0] mul_next;
  logic [16:0] div_shift;
  logic        div_ge;
  logic [15:0] div_rem_next;
  logic [15:0] div_quo_next;

  // New operations are only taken when not iterating.
  assign accept      = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign div_by_zero = op && (b == 16'h0000);

  // State register and all datapath flops, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      op_q     <= 1'b0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      acc_q    <= 32'h0000_0000;
      rem_q    <= 16'h0000;
      res_lo_q <= 16'h0000;
      res_hi_q <= 16'h0000;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
    end
  end

  // Next-state logic: divide-by-zero bypasses RUN entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = div_by_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (cnt_q == 4'd15) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) state_d = div_by_zero ? S_DONE : S_RUN;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state register.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // One iteration of each algorithm, computed from the current registers.
  always_comb begin
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_q[31:16]} + (acc_q[0] ? {1'b0, a_q} : 17'd0);
    mul_next = {mul_sum, acc_q[15:1]};
    // Restoring step: bring in the next dividend bit, subtract if it fits.
    // The 16-bit subtraction is exact because the true difference is < b.
    div_shift    = {rem_q, acc_q[15]};
    div_ge       = (div_shift >= {1'b0, b_q});
    div_rem_next = div_ge ? (div_shift[15:0] - b_q) : div_shift[15:0];
    div_quo_next = {acc_q[14:0], div_ge};
  end

  // Datapath next values: operand capture, iteration, and result load.
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;
    dz_d     = dz_q;
    if (accept) begin
      op_d  = op;
      a_d   = a;
      b_d   = b;
      cnt_d = 4'd0;
      rem_d = 16'h0000;
      acc_d = op ? {16'h0000, a} : {16'h0000, b};
      if (div_by_zero) begin
        res_lo_d = 16'hFFFF;
        res_hi_d = a;
        zero_d   = 1'b0;
        dz_d     = 1'b1;
      end
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q + 4'd1;
      if (op_q) begin
        acc_d = {16'h0000, div_quo_next};
        rem_d = div_rem_next;
      end else begin
        acc_d = mul_next;
      end
      // Last iteration: results come from this cycle's step, not the flops.
      if (cnt_q == 4'd15) begin
        if (op_q) begin
          res_lo_d = div_quo_next;
          res_hi_d = div_rem_next;
        end else begin
          res_lo_d = mul_next[15:0];
          res_hi_d = mul_next[31:16];
        end
        zero_d = ((op_q ? div_quo_next : mul_next[15:0]) == 16'h0000);
        dz_d   = 1'b0;
      end
    end
  end

  assign res_lo = res_lo_q;
  assign res_hi = res_hi_q;
  assign zero   = zero_q;
  assign dz     = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed test-plan cases followed by random operations,
// each checked against plain-arithmetic expectations, including cycle timing.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] res_lo;
  logic [15:0] res_hi;
  logic        zero;
  logic        dz;

  int total = 0;
  int bad   = 0;

  logic [15:0] prev_lo;
  logic [15:0] prev_hi;

  muldiv_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .res_lo (res_lo),
    .res_hi (res_hi),
    .zero   (zero),
    .dz     (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation from a negedge in IDLE or DONE; returns at the
  // negedge where done is seen (so the caller may issue back-to-back).
  task automatic run_op(input logic o, input logic [15:0] ta, input logic [15:0] tb_,
                        input bit poke, input string tag);
    logic [31:0] p;
    logic [15:0] elo;
    logic [15:0] ehi;
    logic        edz;
    int          k;
    int          busy_cnt;
    bit          seen;
    if (!o) begin
      p   = 32'(ta) * 32'(tb_);
      elo = p[31:0] & 32'h0000_FFFF;
      ehi = p[31:16];
      edz = 1'b0;
    end else if (tb_ == 16'h0000) begin
      elo = 16'hFFFF;
      ehi = ta;
      edz = 1'b1;
    end else begin
      elo = ta / tb_;
      ehi = ta % tb_;
      edz = 1'b0;
    end
    start = 1'b1;
    op    = o;
    a     = ta;
    b     = tb_;
    k        = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (k < 40 && !seen) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        op    = ~o;
        a     = 16'($urandom);
        b     = 16'($urandom);
        if (!edz) begin
          chk({tag, " hold_lo"}, 32'(res_lo), 32'(prev_lo));
          chk({tag, " hold_hi"}, 32'(res_hi), 32'(prev_hi));
        end
      end
      if (poke && k == 5) begin
        start = 1'b1;
        op    = 1'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
      end
      if (poke && k == 6) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(k), edz ? 32'd1 : 32'd17);
    chk({tag, " busy_cycles"}, 32'(busy_cnt), edz ? 32'd0 : 32'd16);
    chk({tag, " res_lo"}, 32'(res_lo), 32'(elo));
    chk({tag, " res_hi"}, 32'(res_hi), 32'(ehi));
    chk({tag, " zero"}, 32'(zero), 32'(elo == 16'h0000));
    chk({tag, " dz"}, 32'(dz), 32'(edz));
    prev_lo = elo;
    prev_hi = ehi;
  endtask

  // One cycle after a done with start low: done must have dropped.
  task automatic idle_chk(input string tag);
    start = 1'b0;
    @(negedge clk);
    chk({tag, " done_pulse_single"}, 32'(done), 32'd0);
    chk({tag, " idle_not_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic        ro;
    logic [15:0] ra;
    logic [15:0] rb;
    bit          rpoke;
    int          done_cnt;

    reset   = 1'b1;
    start   = 1'b0;
    op      = 1'b0;
    a       = 16'h0000;
    b       = 16'h0000;
    prev_lo = 16'h0000;
    prev_hi = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset res_lo", 32'(res_lo), 32'd0);
    chk("reset res_hi", 32'(res_hi), 32'd0);
    chk("reset zero", 32'(zero), 32'd0);
    chk("reset dz", 32'(dz), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 16'h1234, 16'h0010, 1'b0, "mul_basic");
    idle_chk("mul_basic");
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, "mul_max");
    idle_chk("mul_max");
    run_op(1'b0, 16'h0100, 16'h0100, 1'b0, "mul_zero");
    idle_chk("mul_zero");
    run_op(1'b1, 16'd1000, 16'd7, 1'b0, "div_1000_7");
    run_op(1'b1, 16'd5, 16'd9, 1'b0, "div_5_9");
    idle_chk("div_5_9");
    run_op(1'b1, 16'h00AB, 16'h0000, 1'b0, "div_zero");
    idle_chk("div_zero");
    run_op(1'b0, 16'h0302, 16'h0041, 1'b1, "start_in_run_mul");
    idle_chk("start_in_run_mul");
    run_op(1'b1, 16'd40000, 16'd123, 1'b1, "start_in_run_div");
    run_op(1'b0, 16'hBEEF, 16'h0003, 1'b0, "b2b_mul");
    run_op(1'b1, 16'h7777, 16'h0000, 1'b0, "b2b_dz");
    run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, "b2b_div1");
    idle_chk("b2b_div1");

    for (int i = 0; i < 40; i++) begin
      ro    = 1'($urandom);
      ra    = 16'($urandom);
      rb    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      rpoke = ($urandom_range(0, 3) == 0);
      run_op(ro, ra, rb, rpoke, "random");
      if ($urandom_range(0, 1) == 1) idle_chk("random");
    end

    // Reset during RUN: make sure there are non-zero results to clear first.
    run_op(1'b0, 16'd3, 16'd5, 1'b0, "pre_reset");
    idle_chk("pre_reset");
    start = 1'b1;
    op    = 1'b0;
    a     = 16'h1111;
    b     = 16'h2222;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid_reset busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset busy", 32'(busy), 32'd0);
    chk("mid_reset done", 32'(done), 32'd0);
    chk("mid_reset res_lo", 32'(res_lo), 32'd0);
    chk("mid_reset res_hi", 32'(res_hi), 32'd0);
    chk("mid_reset zero", 32'(zero), 32'd0);
    chk("mid_reset dz", 32'(dz), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("mid_reset no_done", 32'(done_cnt), 32'd0);
    prev_lo = 16'h0000;
    prev_hi = 16'h0000;
    run_op(1'b1, 16'd1234, 16'd10, 1'b0, "after_reset");
    idle_chk("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
